gpu_rect_renderer: RTL and testbench
====================================

# gpu_rect_renderer

Parametrised successor to the fixed 64-rectangle GPU. It draws an ordered list of up to NUM_RECTS axis-aligned rectangles by direct coordinate comparison. Rectangle state is double-buffered, so software rewrites the shadow bank while the active bank is displayed; banks swap only at a frame boundary. It sits between the rect copy path (write port) and the VGA controller (pixel coordinates in, colour out).

## Interface
Parameters:
- NUM_RECTS, 64: rectangle slots; power of two, 2..64.
- COORD_W, 10: coordinate width in bits.
- DEFAULT_COLOR, `DEFAULT_COLOR: colour when no rectangle covers the pixel.
- TRANSPARENT_KEY, 16'hF81F: colour key, used only with GPU_TRANSPARENCY_EN.

Ports (IDX_W = log2(NUM_RECTS)):
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  shadow-bank write strobe.
- wr_rect  in  IDX_W  slot index.
- wr_field  in  3  field: 0 left, 1 top, 2 right, 3 bottom, 4 colour, 5 enable (bit 0); 6–7 ignored.
- wr_data  in  16  write data; coordinates use [COORD_W-1:0].
- swap_req  in  1  pulse; requests a bank swap at the next frame_start.
- frame_start  in  1  one-cycle pulse before the first pixel of a frame.
- swap_pending  out  1  high from swap_req until the swap completes.
- pix_valid  in  1  x_coord/y_coord valid this cycle.
- x_coord  in  COORD_W  pixel x.
- y_coord  in  COORD_W  pixel y.
- color_valid  out  1  color valid.
- color  out  16  pixel colour.

## Operation
- Each bank stores left, top, right, bottom, colour and enable per slot.
- Hit condition, unsigned: enable && left < x <= right && top < y <= bottom. If left >= right or top >= bottom, the slot never hits.
- Priority: the highest-index hitting slot wins (painter's order). If no slot hits, the output is DEFAULT_COLOR.
- Writes always target the shadow bank; fields 6–7 have no effect.
- Swap FSM states:
  - IDLE: swap_req moves to PENDING.
  - PENDING: frame_start swaps the active/shadow select, copies the new active bank into the new shadow bank in the same edge (both banks equal afterwards), and returns to IDLE.
- swap_req together with frame_start in IDLE:
  - The swap does not occur this frame.
  - The FSM enters PENDING.
- swap_req in PENDING is absorbed.
- wr_en on the swap edge: the write lands in the old shadow bank before the swap. After the edge the value is present in both banks.
- Each pixel uses the bank that was active on its pix_valid cycle. Its colour travels with its hit through the pipeline, so a swap never mixes banks within one pixel.
- Reset (asynchronous):
  - All slots are cleared (enable=0, fields 0).
  - Active select = 0, FSM goes to IDLE, swap_pending=0.
  - The pipeline is flushed: color_valid=0, color=0.
  - A reset mid-pipeline discards all in-flight pixels.

## Timing
- Latency L = 2 + IDX_W clocks from pix_valid to color_valid: 8 for NUM_RECTS=64, 6 for 16.
  - Stage 0: register the coordinates and compare against the active bank, producing the hit vector and colours.
  - Stages 1..IDX_W: one binary-tree priority level per stage, carrying {hit, colour}.
  - Final stage: select colour or DEFAULT_COLOR.
- Fully pipelined: one pixel per clock, no stalls, no back-pressure. color_valid is pix_valid delayed by L.
- While color_valid=0, color=0.
- A shadow write is visible to pixels whose pix_valid falls at least one cycle after the swap edge.
- swap_pending rises the cycle after swap_req and falls the cycle after the swapping frame_start.

## Configuration
- GPU_TRANSPARENCY_EN defined:
  - A slot whose colour equals TRANSPARENT_KEY never hits.
  - Lower slots or DEFAULT_COLOR show through it.
- Undefined:
  - TRANSPARENT_KEY is an ordinary colour.
  - There is no key comparator logic.

## Test plan
- Reset, then stream pixels -> color_valid follows pix_valid by L clocks; every colour is DEFAULT_COLOR (all enables 0).
- Write slot 3 = (10,20,50,60), colour 16'h07E0, enable 1; swap_req; frame_start -> pixel (11,21) gives 16'h07E0; (10,21) and (50,60)+1 in x give DEFAULT_COLOR; pixel (50,60) gives 16'h07E0.
- Overlap: add slot 7 = (0,0,100,100), colour 16'h001F; swap -> pixel (30,30) gives 16'h001F; after disabling slot 7 and swapping, it gives 16'h07E0.
- Swap timing:
  - Write slot 7 to colour 16'hFFFF mid-frame without frame_start -> output unchanged.
  - After frame_start, pixels from the next cycle onward show 16'hFFFF.
  - Pixels already in flight keep the old colour.
- Simultaneous events:
  - swap_req on the frame_start cycle -> no swap this frame; swap_pending=1; swap at the following frame_start.
  - wr_en on the swap edge -> the value is readable from the active bank and persists through one more swap.
- With GPU_TRANSPARENCY_EN, give slot 7 colour TRANSPARENT_KEY -> pixel (30,30) shows slot 3's 16'h07E0. Without the macro, it shows 16'hF81F.
- Assert reset_n low mid-stream -> color_valid and color go to 0 immediately; all slots are cleared.

Source files
------------

// File: rtl/gpu_rect_renderer.sv
// Double-buffered rectangle compositor: painter's-order hit test feeding a pipelined priority tree.
// Optional colour-key transparency is enabled by defining GPU_TRANSPARENCY_EN.
`ifndef DEFAULT_COLOR
`define DEFAULT_COLOR 16'h0000
`endif

module gpu_rect_renderer #(
  parameter int unsigned NUM_RECTS       = 64,
  parameter int unsigned COORD_W         = 10,
  parameter logic [15:0] DEFAULT_COLOR   = `DEFAULT_COLOR,
  parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_RECTS)-1:0] wr_rect,
  input  logic [2:0]                   wr_field,
  input  logic [15:0]                  wr_data,
  input  logic                         swap_req,
  input  logic                         frame_start,
  output logic                         swap_pending,
  input  logic                         pix_valid,
  input  logic [COORD_W-1:0]           x_coord,
  input  logic [COORD_W-1:0]           y_coord,
  output logic                         color_valid,
  output logic [15:0]                  color
);

  localparam int unsigned IdxW = $clog2(NUM_RECTS);

  typedef enum logic {StIdle, StPending} swap_st_e;

  swap_st_e        st_q;
  logic            act_q;
  logic            shadow_sel;
  logic            swap_go;
  logic            swap_pending_q;
  logic [IdxW:0]   vld_q;
  logic            color_valid_q;
  logic [15:0]     color_q;

  // Heap-ordered priority tree: node n has children 2n (lower slot) and 2n+1 (higher slot).
  logic            node_hit_q [1:2*NUM_RECTS-1];
  logic [15:0]     node_col_q [1:2*NUM_RECTS-1];

  assign shadow_sel = ~act_q;
  assign swap_go    = (st_q == StPending) && frame_start;

  for (genvar s = 0; s < NUM_RECTS; s++) begin : g_slot
    logic [COORD_W-1:0] left_q  [2];
    logic [COORD_W-1:0] top_q   [2];
    logic [COORD_W-1:0] right_q [2];
    logic [COORD_W-1:0] bot_q   [2];
    logic [15:0]        col_q   [2];
    logic [1:0]         en_q;
    logic [COORD_W-1:0] left_d, top_d, right_d, bot_d;
    logic [15:0]        col_d;
    logic               en_d;
    logic               wr_sel;
    logic               key_ok;
    logic               hit;

    assign wr_sel = wr_en && (wr_rect == IdxW'(s));

    // Shadow slot with the pending write applied; also the new active/shadow value on a swap.
    always_comb begin
      left_d  = left_q[shadow_sel];
      top_d   = top_q[shadow_sel];
      right_d = right_q[shadow_sel];
      bot_d   = bot_q[shadow_sel];
      col_d   = col_q[shadow_sel];
      en_d    = en_q[shadow_sel];
      if (wr_sel) begin
        case (wr_field)
          3'd0:    left_d  = wr_data[COORD_W-1:0];
          3'd1:    top_d   = wr_data[COORD_W-1:0];
          3'd2:    right_d = wr_data[COORD_W-1:0];
          3'd3:    bot_d   = wr_data[COORD_W-1:0];
          3'd4:    col_d   = wr_data;
          3'd5:    en_d    = wr_data[0];
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int b = 0; b < 2; b++) begin
          left_q[b]  <= '0;
          top_q[b]   <= '0;
          right_q[b] <= '0;
          bot_q[b]   <= '0;
          col_q[b]   <= '0;
        end
        en_q <= '0;
      end else begin
        left_q[shadow_sel]  <= left_d;
        top_q[shadow_sel]   <= top_d;
        right_q[shadow_sel] <= right_d;
        bot_q[shadow_sel]   <= bot_d;
        col_q[shadow_sel]   <= col_d;
        en_q[shadow_sel]    <= en_d;
        if (swap_go) begin
          left_q[act_q]  <= left_d;
          top_q[act_q]   <= top_d;
          right_q[act_q] <= right_d;
          bot_q[act_q]   <= bot_d;
          col_q[act_q]   <= col_d;
          en_q[act_q]    <= en_d;
        end
      end
    end

`ifdef GPU_TRANSPARENCY_EN
    assign key_ok = (col_q[act_q] != TRANSPARENT_KEY);
`else
    assign key_ok = 1'b1;
`endif

    assign hit = en_q[act_q] && key_ok
              && (left_q[act_q] < x_coord) && (x_coord <= right_q[act_q])
              && (top_q[act_q] < y_coord) && (y_coord <= bot_q[act_q]);

    always_ff @(posedge clk) begin
      node_hit_q[NUM_RECTS+s] <= hit;
      node_col_q[NUM_RECTS+s] <= col_q[act_q];
    end
  end

  for (genvar n = 1; n < NUM_RECTS; n++) begin : g_node
    always_ff @(posedge clk) begin
      node_hit_q[n] <= node_hit_q[2*n] | node_hit_q[2*n+1];
      node_col_q[n] <= node_hit_q[2*n+1] ? node_col_q[2*n+1] : node_col_q[2*n];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q           <= StIdle;
      act_q          <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (swap_req) begin
            st_q           <= StPending;
            swap_pending_q <= 1'b1;
          end
        end
        StPending: begin
          if (frame_start) begin
            st_q           <= StIdle;
            act_q          <= ~act_q;
            swap_pending_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q         <= '0;
      color_valid_q <= 1'b0;
      color_q       <= '0;
    end else begin
      vld_q         <= {vld_q[IdxW-1:0], pix_valid};
      color_valid_q <= vld_q[IdxW];
      color_q       <= vld_q[IdxW] ? (node_hit_q[1] ? node_col_q[1] : DEFAULT_COLOR) : '0;
    end
  end

  assign swap_pending = swap_pending_q;
  assign color_valid  = color_valid_q;
  assign color        = color_q;

endmodule

// File: tb/tb_gpu_rect_renderer.sv
// Directed bench for gpu_rect_renderer (16 slots, latency 6), immediate-assertion checks.
module tb_gpu_rect_renderer;

  localparam int unsigned N   = 16;
  localparam int unsigned CW  = 10;
  localparam int unsigned L   = 6;
  localparam logic [15:0] DEF = 16'h1234;
`ifdef GPU_TRANSPARENCY_EN
  localparam logic [15:0] EXP_KEYED = 16'h07E0;
`else
  localparam logic [15:0] EXP_KEYED = 16'hF81F;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [3:0]    wr_rect;
  logic [2:0]    wr_field;
  logic [15:0]   wr_data;
  logic          swap_req;
  logic          frame_start;
  logic          swap_pending;
  logic          pix_valid;
  logic [CW-1:0] x_coord;
  logic [CW-1:0] y_coord;
  logic          color_valid;
  logic [15:0]   color;

  int vectors = 0;
  int errs    = 0;

  gpu_rect_renderer #(
    .NUM_RECTS      (N),
    .COORD_W        (CW),
    .DEFAULT_COLOR  (DEF),
    .TRANSPARENT_KEY(16'hF81F)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_rect     (wr_rect),
    .wr_field    (wr_field),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .swap_pending(swap_pending),
    .pix_valid   (pix_valid),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .color_valid (color_valid),
    .color       (color)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int slot, input int field, input logic [15:0] data);
    wr_en    = 1'b1;
    wr_rect  = 4'(slot);
    wr_field = 3'(field);
    wr_data  = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rect(input int slot, input int l, input int t, input int r, input int b,
                      input logic [15:0] col, input logic en);
    wr(slot, 0, 16'(l));
    wr(slot, 1, 16'(t));
    wr(slot, 2, 16'(r));
    wr(slot, 3, 16'(b));
    wr(slot, 4, col);
    wr(slot, 5, {15'b0, en});
  endtask

  task automatic swap(input string tag);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check({tag, "_pend_hi"}, 16'(swap_pending), 16'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check({tag, "_pend_lo"}, 16'(swap_pending), 16'd0);
  endtask

  task automatic pixel(input int x, input int y, input logic [15:0] exp, input string tag);
    pix_valid = 1'b1;
    x_coord   = CW'(x);
    y_coord   = CW'(y);
    tick();
    pix_valid = 1'b0;
    repeat (L - 1) tick();
    check({tag, "_valid"}, 16'(color_valid), 16'd1);
    check(tag, color, exp);
  endtask

  initial begin
    reset_n     = 1'b0;
    wr_en       = 1'b0;
    wr_rect     = '0;
    wr_field    = '0;
    wr_data     = '0;
    swap_req    = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    x_coord     = '0;
    y_coord     = '0;
    repeat (3) tick();
    check("rst_valid", 16'(color_valid), 16'd0);
    check("rst_color", color, 16'h0000);
    check("rst_pending", 16'(swap_pending), 16'd0);
    reset_n = 1'b1;
    tick();

    // Latency: single pixel, valid exactly L clocks later for one cycle.
    pix_valid = 1'b1;
    x_coord   = 10'd5;
    y_coord   = 10'd5;
    tick();
    pix_valid = 1'b0;
    repeat (L - 2) tick();
    check("lat_early", 16'(color_valid), 16'd0);
    check("lat_early_color", color, 16'h0000);
    tick();
    check("lat_valid", 16'(color_valid), 16'd1);
    check("lat_default", color, DEF);
    tick();
    check("lat_pulse_end", 16'(color_valid), 16'd0);

    // Single rectangle and its boundaries.
    rect(3, 10, 20, 50, 60, 16'h07E0, 1'b1);
    pixel(11, 21, DEF, "pre_swap");
    swap("swap1");
    pixel(11, 21, 16'h07E0, "inside");
    pixel(10, 21, DEF, "left_edge");
    pixel(11, 20, DEF, "top_edge");
    pixel(51, 60, DEF, "right_plus1");
    pixel(50, 61, DEF, "bottom_plus1");
    pixel(50, 60, 16'h07E0, "corner");

    // Overlap: higher slot wins, then disable it. Fields 6/7 must be ignored.
    rect(7, 0, 0, 100, 100, 16'h001F, 1'b1);
    swap("swap2");
    pixel(30, 30, 16'h001F, "overlap");
    wr(7, 5, 16'h0000);
    wr(3, 6, 16'h0000);
    wr(3, 7, 16'h0000);
    swap("swap3");
    pixel(30, 30, 16'h07E0, "slot7_off");

    // Shadow writes invisible until the swap edge; in-flight pixel keeps old bank.
    wr(7, 4, 16'hFFFF);
    wr(7, 5, 16'h0001);
    pixel(30, 30, 16'h07E0, "no_frame_start");
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("st_pend_hi", 16'(swap_pending), 16'd1);
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    x_coord     = 10'd30;
    y_coord     = 10'd30;
    tick();
    frame_start = 1'b0;
    tick();
    pix_valid = 1'b0;
    check("st_pend_lo", 16'(swap_pending), 16'd0);
    repeat (L - 2) tick();
    check("inflight_valid", 16'(color_valid), 16'd1);
    check("inflight_old", color, 16'h07E0);
    tick();
    check("next_valid", 16'(color_valid), 16'd1);
    check("next_new", color, 16'hFFFF);

    // swap_req coincident with frame_start in IDLE: swap deferred one frame.
    wr(7, 4, 16'h001F);
    swap_req    = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    check("coinc_pending", 16'(swap_pending), 16'd1);
    pixel(30, 30, 16'hFFFF, "coinc_noswap");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("coinc_pend_lo", 16'(swap_pending), 16'd0);
    pixel(30, 30, 16'h001F, "coinc_swapped");

    // Write on the swap edge lands in both banks.
    swap_req = 1'b1;
    tick();
    swap_req    = 1'b0;
    frame_start = 1'b1;
    wr(7, 4, 16'hF0F0);
    frame_start = 1'b0;
    pixel(30, 30, 16'hF0F0, "edge_write");
    swap("swap_persist");
    pixel(30, 30, 16'hF0F0, "edge_write_persist");

    // Colour key.
    wr(7, 4, 16'hF81F);
    swap("swap_key");
    pixel(30, 30, EXP_KEYED, "key");

    // Reset mid-stream with a swap pending.
    swap_req = 1'b1;
    tick();
    swap_req  = 1'b0;
    pix_valid = 1'b1;
    x_coord   = 10'd30;
    y_coord   = 10'd30;
    repeat (L + 2) tick();
    check("stream_valid", 16'(color_valid), 16'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(color_valid), 16'd0);
    check("mid_rst_color", color, 16'h0000);
    check("mid_rst_pending", 16'(swap_pending), 16'd0);
    pix_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < L + 1; i++) begin
      tick();
      check("flushed", 16'(color_valid), 16'd0);
    end
    pixel(30, 30, DEF, "cleared_active");
    swap("swap_after_rst");
    pixel(11, 21, DEF, "cleared_shadow");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
